// File: rtl/uart_line_monitor_pkg.sv
// Shared types and constants for the passive 8N1 UART line monitor.
// ASCII words are only consumed when UART_LINE_MONITOR_PASS_FAIL_EN is defined.
package uart_line_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    localparam int unsigned DATA_BITS = 8;

    localparam logic [31:0] ASCII_PASS = 32'h5041_5353;
    localparam logic [31:0] ASCII_FAIL = 32'h4641_494C;

endpackage

// File: rtl/uart_line_monitor_sync.sv
// Two-flop synchronizer for asynchronous idle-high inputs.
// Both stages reset to 1 so a released reset never looks like a start edge.
module uart_line_monitor_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_line_monitor.sv
// Passive 8N1 UART decoder with byte/error counters and optional
// PASS/FAIL string detection (macro UART_LINE_MONITOR_PASS_FAIL_EN).
module uart_line_monitor
    import uart_line_monitor_pkg::*;
#(
    parameter int unsigned CLOCK_CYCLES_PER_BIT = 434,
    parameter int unsigned COUNT_WIDTH          = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   uart_line,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic                   framing_error,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] byte_count,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic                   test_pass,
    output logic                   test_fail
);

    localparam int unsigned TW = $clog2(CLOCK_CYCLES_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLOCK_CYCLES_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_M1  = TW'(CLOCK_CYCLES_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                   line_s;
    state_e                 state_q;
    logic [TW-1:0]          timer_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   ferr_q;
    logic [COUNT_WIDTH-1:0] byte_cnt_q;
    logic [COUNT_WIDTH-1:0] err_cnt_q;

    uart_line_monitor_sync u_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (uart_line),
        .q_o   (line_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!line_s) begin
                        state_q <= ST_START;
                        timer_q <= '0;
                    end
                end
                ST_START: begin
                    // Mid-start-bit check rejects short low glitches
                    if (timer_q == HALF_M1) begin
                        if (line_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q   <= ST_DATA;
                            timer_q   <= '0;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_q == BIT_M1) begin
                        timer_q   <= '0;
                        shift_q   <= {line_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (timer_q == BIT_M1) begin
                        timer_q <= '0;
                        if (line_s) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            if (byte_cnt_q != '1) begin
                                byte_cnt_q <= byte_cnt_q + COUNT_WIDTH'(1);
                            end
                            state_q <= ST_IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + COUNT_WIDTH'(1);
                            end
                            state_q <= ST_BREAK;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_BREAK: begin
                    if (line_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != ST_IDLE);
    assign byte_count    = byte_cnt_q;
    assign error_count   = err_cnt_q;

`ifdef UART_LINE_MONITOR_PASS_FAIL_EN
    logic [31:0] hist_q;
    logic [31:0] hist_d;
    logic        pass_q;
    logic        fail_q;

    assign hist_d = {hist_q[23:0], rx_data_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (ferr_q) begin
            hist_q <= '0;
        end else if (rx_valid_q) begin
            hist_q <= hist_d;
            if (hist_d == ASCII_PASS) begin
                pass_q <= 1'b1;
            end
            if (hist_d == ASCII_FAIL) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign test_pass = pass_q;
    assign test_fail = fail_q;
`else
    assign test_pass = 1'b0;
    assign test_fail = 1'b0;
`endif

endmodule
